deserializer_frame_ctrl: RTL and testbench

//  Frame sequencer for the 8-bit serial-to-parallel deserializer.

---
 rtl/deserializer_frame_ctrl_pkg.sv | 15 +
 rtl/deserializer_frame_ctrl_if.sv | 31 +++
 rtl/deserializer_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_deserializer_frame_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/deserializer_frame_ctrl_pkg.sv
// Shared types and sizing for the deserializer frame sequencer.
// Optional parity feature macro: DESER_PARITY_CHECK_EN.
package deser_pkg;

  localparam int DESER_DATA_BITS = 8;
  localparam int CNT_W           = $clog2(DESER_DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/deserializer_frame_ctrl_if.sv
// Serial-side and consumer-side signal bundle of the frame sequencer.
// The slave modport is the sequencer; master is the pin/deserializer/consumer side.
interface deser_if #(
  parameter int DATA_BITS = 8
);

  logic                 in_bit;
  logic [DATA_BITS-1:0] in_des_data;
  logic                 in_ready;
  logic                 out_des_enable;
  logic                 out_des_bit;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_busy;
  logic                 out_frame_err;
  logic                 out_overrun;
  logic                 out_parity_err;

  modport slave (
    input  in_bit, in_des_data, in_ready,
    output out_des_enable, out_des_bit, out_data, out_valid,
           out_busy, out_frame_err, out_overrun, out_parity_err
  );

  modport master (
    output in_bit, in_des_data, in_ready,
    input  out_des_enable, out_des_bit, out_data, out_valid,
           out_busy, out_frame_err, out_overrun, out_parity_err
  );

endinterface

// File: rtl/deserializer_frame_ctrl.sv
// Frame sequencer: start-bit detect, deserializer gating, stop/parity check, valid/ready output.
// Define DESER_PARITY_CHECK_EN to add an even-parity bit after the data bits.
module deserializer_frame_ctrl
  import deser_pkg::*;
#(
  parameter int DATA_BITS = DESER_DATA_BITS,
  parameter int STOP_BITS = 1
) (
  input  logic   in_clock,
  input  logic   in_reset_n,
  deser_if.slave bus
);

  localparam int CW = $clog2(DATA_BITS + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef DESER_PARITY_CHECK_EN
  logic                 perr_q, perr_d;
`endif

  // State, counter, output word and sticky flags.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef DESER_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state decode; a word consumed at this edge frees the slot for a delivery at the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef DESER_PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    if (valid_q && bus.in_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      IDLE: begin
        if (!bus.in_bit) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          cnt_d = '0;
`ifdef DESER_PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef DESER_PARITY_CHECK_EN
      PARITY: begin
        if (^{bus.in_des_data, bus.in_bit}) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        cnt_d   = '0;
        state_d = STOP;
      end
`endif
      STOP: begin
        if (!bus.in_bit) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(STOP_BITS - 1)) begin
          state_d = IDLE;
          if (!valid_q || bus.in_ready) begin
            data_d  = bus.in_des_data;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.out_des_enable = (state_q == DATA);
  assign bus.out_des_bit    = bus.in_bit;
  assign bus.out_data       = data_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_busy       = (state_q != IDLE);
  assign bus.out_frame_err  = ferr_q;
  assign bus.out_overrun    = ovr_q;
`ifdef DESER_PARITY_CHECK_EN
  assign bus.out_parity_err = perr_q;
`else
  assign bus.out_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer_frame_ctrl.sv
// Directed bench for deserializer_frame_ctrl with a real MSB-first shift deserializer.
// Delivered words are queued by the stimulus and popped when the DUT presents them.
module tb_deserializer_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deser_if #(.DATA_BITS(8)) bus();

  deserializer_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  logic [7:0] des_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) des_q <= 8'h00;
    else if (bus.out_des_enable) des_q <= {des_q[6:0], bus.out_des_bit};
  end
  assign bus.in_des_data = des_q;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic exp_valid = 1'b0;
  logic exp_ovr = 1'b0;
  logic exp_ferr = 1'b0;
  logic exp_perr = 1'b0;
`ifdef DESER_PARITY_CHECK_EN
  logic par_forced = 1'b0;
  logic par_val = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_step(input logic b);
    bus.in_bit = b;
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, {7'd0, bus.out_valid}, {7'd0, exp_valid});
    chk({tag, "_overrun"}, {7'd0, bus.out_overrun}, {7'd0, exp_ovr});
    chk({tag, "_frame_err"}, {7'd0, bus.out_frame_err}, {7'd0, exp_ferr});
    chk({tag, "_parity_err"}, {7'd0, bus.out_parity_err}, {7'd0, exp_perr});
    chk({tag, "_busy"}, {7'd0, bus.out_busy}, 8'h00);
    if (exp_valid && exp_q.size() > 0) chk({tag, "_data"}, bus.out_data, exp_q[0]);
  endtask

  // Start bit, 8 data bits MSB first, optional parity, stop bit; rdy is in_ready on the stop edge.
  task automatic send_frame(input string tag, input logic [7:0] w, input logic stop_b, input logic rdy);
    bus.in_bit = 1'b0;
    chk({tag, "_des_bit"}, {7'd0, bus.out_des_bit}, 8'h00);
    @(negedge clk);
    chk({tag, "_busy_start"}, {7'd0, bus.out_busy}, 8'h01);
    chk({tag, "_des_en"}, {7'd0, bus.out_des_enable}, 8'h01);
    for (int i = 7; i >= 0; i--) bit_step(w[i]);
`ifdef DESER_PARITY_CHECK_EN
    begin
      logic p;
      p = par_forced ? par_val : ^w;
      bit_step(p);
      if (^{w, p}) exp_perr = 1'b1;
    end
`endif
    chk({tag, "_valid_pre_stop"}, {7'd0, bus.out_valid}, {7'd0, exp_valid});
    bus.in_ready = rdy;
    bus.in_bit   = stop_b;
    if (exp_valid && rdy) begin
      void'(exp_q.pop_front());
      exp_valid = 1'b0;
    end
    if (stop_b) begin
      if (!exp_valid) begin
        exp_q.push_back(w);
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else begin
      exp_ferr = 1'b1;
    end
    @(negedge clk);
    bus.in_ready = 1'b0;
    bus.in_bit   = 1'b1;
    check_state(tag);
  endtask

  task automatic consume(input string tag);
    bus.in_ready = 1'b1;
    @(negedge clk);
    bus.in_ready = 1'b0;
    if (exp_valid) begin
      void'(exp_q.pop_front());
      exp_valid = 1'b0;
    end
    chk({tag, "_consumed"}, {7'd0, bus.out_valid}, {7'd0, exp_valid});
  endtask

  initial begin
    bus.in_bit   = 1'b1;
    bus.in_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_des_en", {7'd0, bus.out_des_enable}, 8'h00);
    check_state("rst");
    rst_n = 1'b1;

    // 1: idle line then a clean frame
    repeat (3) bit_step(1'b1);
    chk("idle_busy", {7'd0, bus.out_busy}, 8'h00);
    chk("idle_des_bit", {7'd0, bus.out_des_bit}, 8'h01);
    send_frame("t1_a5", 8'hA5, 1'b1, 1'b0);
    consume("t1");

    // 2: bad stop bit, then a good frame
    send_frame("t2_3c", 8'h3C, 1'b0, 1'b0);
    send_frame("t2_01", 8'h01, 1'b1, 1'b0);
    consume("t2");

    // 3: back-to-back frames with no consumer
    send_frame("t3_ff", 8'hFF, 1'b1, 1'b0);
    send_frame("t3_00", 8'h00, 1'b1, 1'b0);
    consume("t3");

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();

    // 4: same pair, consumer ready on the second completion edge
    send_frame("t4_ff", 8'hFF, 1'b1, 1'b0);
    send_frame("t4_00", 8'h00, 1'b1, 1'b1);
    consume("t4");
    send_frame("t4_77", 8'h77, 1'b1, 1'b0);

    // 5: reset while mid-frame with a word pending
    bit_step(1'b0);
    bit_step(1'b1);
    bit_step(1'b1);
    bit_step(1'b0);
    bit_step(1'b0);
    chk("t5_busy_mid", {7'd0, bus.out_busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("t5_rst_data", bus.out_data, 8'h00);
    chk("t5_rst_des_en", {7'd0, bus.out_des_enable}, 8'h00);
    check_state("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame("t5_5a", 8'h5A, 1'b1, 1'b0);
    consume("t5");

`ifdef DESER_PARITY_CHECK_EN
    // 6: parity error still delivers; correct parity does not flag
    par_forced = 1'b1;
    par_val    = 1'b1;
    send_frame("t6_bad", 8'h0F, 1'b1, 1'b0);
    consume("t6_bad");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    par_val = 1'b0;
    send_frame("t6_good", 8'h0F, 1'b1, 1'b0);
    consume("t6_good");
    par_forced = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
